// File: rtl/bram_write_arbiter.sv
// N-channel write arbiter for frame-buffer BRAM port A: per-channel FIFOs, fixed/round-robin grant, idle-slot read-back.
// Optional ARB_DROP_COUNT_EN adds per-channel saturating dropped-push counters on o_drop_cnt.
module bram_write_arbiter #(
  parameter int CHANNELS   = 4,
  parameter int SEL_WIDTH  = 2,
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           i_reset,
  input  logic                           i_mode,
  input  logic [SEL_WIDTH-1:0]           i_sel,
  input  logic [CHANNELS-1:0]            i_we,
  input  logic [CHANNELS*ADDR_WIDTH-1:0] i_addr,
  input  logic [CHANNELS*DATA_WIDTH-1:0] i_data,
  output logic [CHANNELS-1:0]            o_full,
  input  logic                           i_rd_req,
  input  logic [ADDR_WIDTH-1:0]          i_rd_addr,
  output logic [DATA_WIDTH-1:0]          o_rd_data,
  output logic                           o_rd_valid,
  output logic                           o_wea,
  output logic [ADDR_WIDTH-1:0]          o_addra,
  output logic [DATA_WIDTH-1:0]          o_dia,
  input  logic [DATA_WIDTH-1:0]          i_doa
`ifdef ARB_DROP_COUNT_EN
  ,
  output logic [CHANNELS*16-1:0]         o_drop_cnt
`endif
);

  localparam int PTR_W = $clog2(CHANNELS);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;
  localparam int EW    = ADDR_WIDTH + DATA_WIDTH;

  logic [EW-1:0]       mem       [CHANNELS][FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr    [CHANNELS];
  logic [AW-1:0]       rd_ptr    [CHANNELS];
  logic [CW-1:0]       count     [CHANNELS];
  logic [CW-1:0]       count_nxt [CHANNELS];
  logic [CHANNELS-1:0] not_empty;
  logic [CHANNELS-1:0] push;
  logic [CHANNELS-1:0] pop;
  logic [PTR_W-1:0]    rr_ptr;
  logic                grant_valid;
  logic [PTR_W-1:0]    grant_idx;
  logic [EW-1:0]       head;
  logic                rd_p1;
  logic                rd_p2;
  logic                rd_issue;

  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      not_empty[k] = (count[k] != '0);
    end
  end

  // Round robin picks the non-empty channel at the smallest distance past rr_ptr.
  always_comb begin
    int d;
    int best_d;
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    grant_valid = 1'b0;
    grant_idx   = '0;
    best_d      = CHANNELS;
    d           = 0;
    if (i_mode) begin
      for (int k = 0; k < CHANNELS; k++) begin
        d = k - int'(rr_ptr) - 1;
        if (d < 0) d = d + CHANNELS;
        if (not_empty[k] && d < best_d) begin
          best_d    = d;
          grant_idx = PTR_W'(k);
        end
      end
      grant_valid = (best_d < CHANNELS);
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (not_empty[k] && int'(i_sel) == k) begin
          grant_valid = 1'b1;
          grant_idx   = PTR_W'(k);
        end
      end
    end
  end

  // A push onto a full FIFO is still accepted when the same edge pops it.
  always_comb begin
    head = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      pop[k]       = grant_valid && (grant_idx == PTR_W'(k));
      push[k]      = i_we[k] && (!o_full[k] || pop[k]);
      count_nxt[k] = count[k] + {{(CW-1){1'b0}}, push[k]} - {{(CW-1){1'b0}}, pop[k]};
      if (pop[k]) head = mem[k][rd_ptr[k]];
    end
  end

  // NOTE: FIFO storage carries no reset; the pointers and counts alone define what is valid.
  always_ff @(posedge clk) begin
    for (int k = 0; k < CHANNELS; k++) begin
      if (push[k]) begin
        mem[k][wr_ptr[k]] <= {i_addr[k*ADDR_WIDTH +: ADDR_WIDTH], i_data[k*DATA_WIDTH +: DATA_WIDTH]};
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      for (int k = 0; k < CHANNELS; k++) begin
        wr_ptr[k] <= '0;
        rd_ptr[k] <= '0;
        count[k]  <= '0;
      end
      o_full <= '0;
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (push[k]) wr_ptr[k] <= wr_ptr[k] + AW'(1);
        if (pop[k])  rd_ptr[k] <= rd_ptr[k] + AW'(1);
        count[k]  <= count_nxt[k];
        o_full[k] <= (count_nxt[k] == CW'(FIFO_DEPTH));
      end
    end
  end

  // A read issues only in a grant-free cycle; the valid cycle also blocks so a held request cannot re-issue.
  assign rd_issue = i_rd_req && !grant_valid && !rd_p1 && !rd_p2 && !o_rd_valid;

  always_ff @(posedge clk) begin
    if (i_reset) begin
      o_wea      <= 1'b0;
      o_addra    <= '0;
      o_dia      <= '0;
      rr_ptr     <= PTR_W'(CHANNELS - 1);
      rd_p1      <= 1'b0;
      rd_p2      <= 1'b0;
      o_rd_valid <= 1'b0;
      o_rd_data  <= '0;
    end else begin
      o_wea <= grant_valid;
      if (grant_valid) begin
        o_addra <= head[EW-1:DATA_WIDTH];
        o_dia   <= head[DATA_WIDTH-1:0];
        rr_ptr  <= grant_idx;
      end else if (rd_issue) begin
        o_addra <= i_rd_addr;
      end
      rd_p1      <= rd_issue;
      rd_p2      <= rd_p1;
      o_rd_valid <= rd_p2;
      if (rd_p2) o_rd_data <= i_doa;
    end
  end

`ifdef ARB_DROP_COUNT_EN
  logic [15:0] drop_cnt [CHANNELS];

  always_ff @(posedge clk) begin
    if (i_reset) begin
      for (int k = 0; k < CHANNELS; k++) drop_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (i_we[k] && !push[k] && drop_cnt[k] != 16'hFFFF) drop_cnt[k] <= drop_cnt[k] + 16'd1;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < CHANNELS; k++) o_drop_cnt[k*16 +: 16] = drop_cnt[k];
  end
`endif

endmodule
